seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
Sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- A rising edge on init latches both operands and starts a fixed-length iteration.
- done pulses for one cycle when result is valid.
- Small arithmetic co-processor core. A host/bus wrapper drives init and polls done.

Parameters:
- WIDTH, 16, operand width; result width is 2*WIDTH; iteration count is WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  start request; only its rising edge counts.
- op_A  input  WIDTH  multiplicand, unsigned.
- op_B  input  WIDTH  multiplier, unsigned.
- result  output  2*WIDTH  registered product; holds last completed value.
- done  output  1  registered one-cycle completion pulse.

Behaviour:
- Reset (async, active-high) drives the following to 0: state=IDLE, result, done, init_q, internal registers. Reset mid-operation aborts the multiply; result returns to 0.
- init_q is a registered copy of init. start = init & ~init_q. A held-high init starts exactly once.
- States:
  - IDLE: on start, load acc_a = zero-extended op_A (2*WIDTH bits), sh_b = op_B, prod = 0, cnt = 0; go to RUN. Without start, stay in IDLE.
  - RUN: each cycle, if sh_b[0] then prod = prod + acc_a (mod 2^(2*WIDTH); no overflow is possible). Then acc_a <<= 1, sh_b >>= 1, cnt++. After WIDTH RUN cycles, go to DONE; on that same edge, result <= final prod.
  - DONE: done = 1 for exactly this one cycle; next state is IDLE.
- Latency: done is high in the cycle following the 17th rising edge after the edge that sampled start (WIDTH=16: 1 load edge + 16 RUN edges). The result value is valid in that same cycle and stays stable until the next completion or reset.
- Operands are sampled only at start. op_A/op_B changes during RUN are ignored.
- start during RUN or DONE is ignored; no restart and no queuing. init_q keeps tracking, so init must fall and rise again to launch a new multiply.
- start arriving in the same cycle as DONE is also ignored.
- Operands of 0 still take the full latency (unless EARLY_TERM_EN). result = 0.
- Max case: 0xFFFF*0xFFFF = 0xFFFE0001, no truncation.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: RUN exits to DONE as soon as the shifted sh_b equals 0. The number of RUN cycles is max(1, index of op_B MSB + 1); op_B = 0 gives 1 RUN cycle. Result values are identical to the non-macro build.
- Undefined: fixed WIDTH RUN cycles regardless of operands.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - WIDTH default constant;
  - counter width localparam, $clog2(WIDTH+1).
- One natural sub-module: seq_mult_dp. It holds acc_a, sh_b, prod and cnt, with load/step controls and a last/zero status output.
- The top level keeps the FSM, init edge detection, and the result/done registers.

Test Plan:
- Reset, then init pulsed high for 2 cycles with op_A=0x0055, op_B=0x0033 -> done pulses once, 17 cycles after start; result=0x000010EF; done low in all other cycles.
- op_A=0xFFFF, op_B=0xFFFF -> result=0xFFFE0001. Also op_A=0x1234, op_B=0 -> result=0 with the same latency.
- init held high for 50 cycles -> exactly one done pulse. Drop init and raise it again with new operands 0x0003*0x0007 -> second pulse, result=0x00000015.
- init toggled and operands changed while in RUN -> ignored; result equals the original product; one done pulse.
- Assert reset in the middle of RUN (cycle 8) -> result=0 and done=0 immediately. No done pulse follows; a fresh init afterwards works normally.
- With SEQ_MULT_EARLY_TERM_EN: 0x0055*0x0033 -> done 7 cycles after start, result=0x000010EF. op_B=0 -> done 2 cycles after start, result=0.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and constants for the sequential multiplier.
//   state_e      : FSM state encoding (idle / run / done)
//   DefaultWidth : default operand width
//   CntWidth     : iteration counter width for the default operand width
//   cnt_width()  : counter width for an arbitrary operand width
package seq_mult_pkg;

  localparam int unsigned DefaultWidth = 16;

  // Counter must be able to hold the value WIDTH itself.
  localparam int unsigned CntWidth = $clog2(DefaultWidth + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: host-side bundle of the multiplier.
//   init   : start request, rising edge starts a multiply
//   op_A   : multiplicand (WIDTH bits, unsigned)
//   op_B   : multiplier   (WIDTH bits, unsigned)
//   result : registered product (2*WIDTH bits)
//   done   : one-cycle completion pulse
// Modports: master = host / bus wrapper, slave = multiplier core.
interface seq_mult_if #(
  parameter int unsigned WIDTH = 16
);

  logic                 init;
  logic [WIDTH-1:0]     op_A;
  logic [WIDTH-1:0]     op_B;
  logic [2*WIDTH-1:0]   result;
  logic                 done;

  modport master (
    output init,
    output op_A,
    output op_B,
    input  result,
    input  done
  );

  modport slave (
    input  init,
    input  op_A,
    input  op_B,
    output result,
    output done
  );

endinterface

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: shift-and-add datapath.
//   clk, reset    : clock, asynchronous active-high reset
//   load_i        : capture operands, clear product and counter
//   step_i        : perform one shift-and-add iteration
//   op_a_i/op_b_i : operands, sampled only on load_i
//   prod_next_o   : product value after the current step (written to result on the last step)
//   last_o        : the current step is the final iteration
// Build option: SEQ_MULT_EARLY_TERM_EN ends iteration once the remaining multiplier bits are zero.
module seq_mult_dp #(
  parameter int unsigned Width    = 16,
  parameter int unsigned CntWidth = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [Width-1:0]     op_a_i,
  input  logic [Width-1:0]     op_b_i,
  output logic [2*Width-1:0]   prod_next_o,
  output logic                 last_o
);

  logic [2*Width-1:0] acc_a_q, acc_a_d;
  logic [2*Width-1:0] prod_q, prod_d;
  logic [Width-1:0]   sh_b_q, sh_b_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [2*Width-1:0] prod_sum;
  logic               cnt_last;

  // Product cannot exceed 2*Width bits, so the sum never wraps.
  assign prod_sum    = prod_q + (sh_b_q[0] ? acc_a_q : '0);
  assign prod_next_o = prod_sum;
  assign cnt_last    = (cnt_q == CntWidth'(Width - 1));

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Stop once the shifted multiplier would be zero; the count bound is a safety net only.
  assign last_o = ((sh_b_q >> 1) == '0) || cnt_last;
`else
  assign last_o = cnt_last;
`endif

  always_comb begin
    acc_a_d = acc_a_q;
    prod_d  = prod_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      acc_a_d = {{Width{1'b0}}, op_a_i};
      sh_b_d  = op_b_i;
      prod_d  = '0;
      cnt_d   = '0;
    end else if (step_i) begin
      prod_d  = prod_sum;
      acc_a_d = acc_a_q << 1;
      sh_b_d  = sh_b_q >> 1;
      cnt_d   = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_a_q <= '0;
      prod_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      acc_a_q <= acc_a_d;
      prod_q  <= prod_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// seq_mult: sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier.
//   clk   : system clock
//   reset : asynchronous active-high reset, aborts any multiply in progress
//   bus   : seq_mult_if slave (init, op_A, op_B in; result, done out)
// A rising edge on init starts a multiply from idle; done pulses one cycle with result valid.
// Build option: SEQ_MULT_EARLY_TERM_EN shortens the run phase (see seq_mult_dp).
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic      clk,
  input  logic      reset,
  seq_mult_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic                 init_q;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 done_q, done_d;
  logic                 start;
  logic                 load;
  logic                 step;
  logic                 last;
  logic [2*WIDTH-1:0]   prod_next;

  // init_q tracks init in every state, so a held init never retriggers.
  assign start = bus.init & ~init_q;

  seq_mult_dp #(
    .Width    (WIDTH),
    .CntWidth (CntW)
  ) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_i      (step),
    .op_a_i      (bus.op_A),
    .op_b_i      (bus.op_B),
    .prod_next_o (prod_next),
    .last_o      (last)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (last) begin
          result_d = prod_next;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        // Any start seen here is dropped.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      init_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= bus.init;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

  localparam int unsigned W = 16;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  typedef struct {
    logic [2*W-1:0] prod;
    int unsigned    due;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  int unsigned    cyc = 0;
  int             checks = 0;
  int             errors = 0;
  exp_t           sb[$];
  logic [2*W-1:0] last_prod = '0;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Number of RUN cycles for a given multiplier.
  function automatic int unsigned run_cycles(input logic [W-1:0] b);
    int unsigned n;
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return EarlyTerm ? n : W;
  endfunction

  // Scoreboard side: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d got done=1 want done=0", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.result !== e.prod) begin
          errors++;
          $display("FAIL result got %h want %h", bus.result, e.prod);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL done_cycle got %0d want %0d", cyc, e.due);
        end
        last_prod = e.prod;
      end
    end
  end

  // Raise init after an edge; it is sampled on the following edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, output int unsigned due);
    exp_t e;
    @(posedge clk); #1;
    bus.op_A = a;
    bus.op_B = b;
    bus.init = 1'b1;
    due = cyc + 1 + run_cycles(b);
    e.prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic drop_init();
    @(posedge clk); #1;
    bus.init = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got pending=%0d want 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== last_prod) begin
      errors++;
      $display("FAIL %s_hold got %h want %h", name, bus.result, last_prod);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.init = 1'b0;
    bus.op_A = '0;
    bus.op_B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== '0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", bus.result);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", bus.done);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int unsigned due;
    launch(16'h0055, 16'h0033, due);
    @(posedge clk); #1;
    drop_init();
    wait_idle("basic");
  endtask

  task automatic test_corners();
    int unsigned due;
    launch(16'hFFFF, 16'hFFFF, due);
    drop_init();
    wait_idle("max");
    launch(16'h1234, 16'h0000, due);
    drop_init();
    wait_idle("zero_b");
    launch(16'h0000, 16'h8001, due);
    drop_init();
    wait_idle("zero_a");
  endtask

  task automatic test_held();
    int unsigned due;
    launch(16'h0101, 16'h0202, due);
    repeat (50) @(posedge clk);
    #1;
    bus.init = 1'b0;
    wait_idle("held");
    launch(16'h0003, 16'h0007, due);
    drop_init();
    wait_idle("relaunch");
  endtask

  task automatic test_ignore();
    int unsigned due;
    launch(16'h00AB, 16'h00CD, due);
    while (cyc + 2 < due) begin
      @(posedge clk); #1;
      bus.init = ~bus.init;
      bus.op_A = 16'($urandom);
      bus.op_B = 16'($urandom);
    end
    @(posedge clk); #1;
    bus.init = 1'b0;
    // Rising edge lands on the edge taken in the DONE state.
    while (cyc < due) begin
      @(posedge clk); #1;
    end
    bus.init = 1'b1;
    drop_init();
    wait_idle("ignore");
  endtask

  task automatic test_reset_mid();
    int unsigned due;
    int unsigned load_cyc;
    launch(16'h1111, 16'h0F0F, due);
    load_cyc = due - run_cycles(16'h0F0F);
    drop_init();
    while (cyc < load_cyc + 8) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.result !== '0) begin
      errors++;
      $display("FAIL midreset_result got %h want 0", bus.result);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_done got %b want 0", bus.done);
    end
    sb.delete();
    last_prod = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== '0) begin
      errors++;
      $display("FAIL midreset_after got %h want 0", bus.result);
    end
    launch(16'h0055, 16'h0033, due);
    drop_init();
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_held();
    test_ignore();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
